// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load handshake and round-key read port of the AES-256 key-schedule controller.
// With AES_KS_ZEROIZE_EN defined the bundle also carries zeroize_i.
interface aes_key_sched_ctrl_if;
  logic         key_v_i;
  logic [255:0] key_i;
  logic         key_ready_o;
  logic         busy_o;
  logic         done_o;
  logic         keys_valid_o;
  logic [3:0]   rk_idx_i;
  logic [127:0] rk_o;
`ifdef AES_KS_ZEROIZE_EN
  logic         zeroize_i;

  modport slave (
    input  key_v_i, key_i, rk_idx_i, zeroize_i,
    output key_ready_o, busy_o, done_o, keys_valid_o, rk_o
  );
  modport master (
    output key_v_i, key_i, rk_idx_i, zeroize_i,
    input  key_ready_o, busy_o, done_o, keys_valid_o, rk_o
  );
`else
  modport slave (
    input  key_v_i, key_i, rk_idx_i,
    output key_ready_o, busy_o, done_o, keys_valid_o, rk_o
  );
  modport master (
    output key_v_i, key_i, rk_idx_i,
    input  key_ready_o, busy_o, done_o, keys_valid_o, rk_o
  );
`endif
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES-256 key-schedule controller: one round_key step per cycle into an 8x256 store,
// with a registered 128-bit round-key read port. AES_KS_ZEROIZE_EN adds a synchronous zeroize.
module aes_key_sched_ctrl #(
  parameter int unsigned KEY_W     = 256,
  parameter int unsigned RK_W      = 128,
  parameter int unsigned NUM_STEPS = 7
) (
  input logic                   clk_i,
  input logic                   reset_i,
  aes_key_sched_ctrl_if.slave   ks_if
);

  localparam int unsigned NumSlots = NUM_STEPS + 1;

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [KEY_W-1:0] round_key(input logic [KEY_W-1:0] prev,
                                                 input logic [2:0]       r);
    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [7:0]  rcon;
    for (int i = 0; i < 8; i++) w[i] = prev[KEY_W-1-32*i -: 32];
    rcon = 8'h01 << (r - 3'd1);
    n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h000000};
    for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i-1];
    n[4] = w[4] ^ sub_word(n[3]);
    for (int i = 5; i < 8; i++) n[i] = w[i] ^ n[i-1];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  state_e            r_state;
  logic [2:0]        r_step;
  logic [KEY_W-1:0]  r_slot [NumSlots];
  logic [RK_W-1:0]   r_rk;
  logic              r_key_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_keys_valid;

  logic              w_accept;
  logic [KEY_W-1:0]  w_next;
  logic [KEY_W-1:0]  w_sel;
  logic [RK_W-1:0]   w_rk;

  assign w_accept = ks_if.key_v_i & r_key_ready;
  assign w_next   = round_key(r_slot[r_step - 3'd1], r_step);

  always_comb begin
    w_sel = r_slot[ks_if.rk_idx_i[3:1]];
    w_rk  = ks_if.rk_idx_i[0] ? w_sel[RK_W-1:0] : w_sel[KEY_W-1:RK_W];
    // Index 15 is the unused lower half of the last slot.
    if (ks_if.rk_idx_i == 4'd15) w_rk = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= StIdle;
      r_step       <= 3'd0;
      r_rk         <= '0;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      for (int i = 0; i < NumSlots; i++) r_slot[i] <= '0;
    end
`ifdef AES_KS_ZEROIZE_EN
    else if (ks_if.zeroize_i) begin
      r_state      <= StIdle;
      r_step       <= 3'd0;
      r_rk         <= '0;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      for (int i = 0; i < NumSlots; i++) r_slot[i] <= '0;
    end
`endif
    else begin
      r_rk   <= w_rk;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StReady: begin
          if (w_accept) begin
            r_slot[0]    <= ks_if.key_i;
            r_step       <= 3'd1;
            r_state      <= StExpand;
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
          end
        end
        StExpand: begin
          r_slot[r_step] <= w_next;
          if (r_step == 3'(NUM_STEPS)) begin
            r_state      <= StReady;
            r_done       <= 1'b1;
            r_keys_valid <= 1'b1;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ks_if.key_ready_o  = r_key_ready;
  assign ks_if.busy_o       = r_busy;
  assign ks_if.done_o       = r_done;
  assign ks_if.keys_valid_o = r_keys_valid;
  assign ks_if.rk_o         = r_rk;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: FIPS-197 C.3 and all-zero key schedules, handshake
// timing, async reset abort, index 15, and zeroize when AES_KS_ZEROIZE_EN is defined.
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [255:0] KeyC3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KeyAlt = {8{32'hdeadbeef}};

  aes_key_sched_ctrl_if ks_if ();

  aes_key_sched_ctrl dut (
    .clk_i   (clk),
    .reset_i (rst),
    .ks_if   (ks_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    ks_if.rk_idx_i = idx;
    tick();
    check(tag, ks_if.rk_o, exp);
  endtask

  initial begin
    ks_if.key_v_i  = 1'b0;
    ks_if.key_i    = '0;
    ks_if.rk_idx_i = 4'd0;
`ifdef AES_KS_ZEROIZE_EN
    ks_if.zeroize_i = 1'b0;
`endif
    // 1. asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("rst_key_ready", ks_if.key_ready_o, 1);
    check("rst_busy", ks_if.busy_o, 0);
    check("rst_done", ks_if.done_o, 0);
    check("rst_keys_valid", ks_if.keys_valid_o, 0);
    check("rst_rk", ks_if.rk_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // 2/3. accept C.3 key, then hold key_v_i with another key during expansion
    ks_if.key_v_i = 1'b1;
    ks_if.key_i   = KeyC3;
    tick();
    check("acc_busy", ks_if.busy_o, 1);
    check("acc_ready", ks_if.key_ready_o, 0);
    ks_if.key_i = KeyAlt;
    for (int i = 1; i < 7; i++) tick();
    check("t6_keys_valid", ks_if.keys_valid_o, 0);
    tick();
    check("t7_keys_valid", ks_if.keys_valid_o, 1);
    check("t7_done", ks_if.done_o, 1);
    check("t7_busy", ks_if.busy_o, 0);
    ks_if.key_v_i = 1'b0;
    tick();
    check("t8_done", ks_if.done_o, 0);
    check("t8_keys_valid", ks_if.keys_valid_o, 1);
    read_rk(4'd0, 128'h000102030405060708090a0b0c0d0e0f, "c3_rk0");
    read_rk(4'd1, 128'h101112131415161718191a1b1c1d1e1f, "c3_rk1");
    read_rk(4'd2, 128'ha573c29fa176c498a97fce93a572c09c, "c3_rk2");
    read_rk(4'd3, 128'h1651a8cd0244beda1a5da4c10640bade, "c3_rk3");
    read_rk(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "c3_rk14");
    read_rk(4'd15, 128'h0, "c3_rk15");

    // 4. rekey with zero key in READY; same-cycle read sees the old store
    ks_if.rk_idx_i = 4'd0;
    ks_if.key_v_i  = 1'b1;
    ks_if.key_i    = '0;
    tick();
    ks_if.key_v_i = 1'b0;
    check("rekey_keys_valid", ks_if.keys_valid_o, 0);
    check("rekey_old_rk0", ks_if.rk_o, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 7; i++) tick();
    check("z_keys_valid", ks_if.keys_valid_o, 1);
    check("z_done", ks_if.done_o, 1);
    read_rk(4'd0, 128'h0, "z_rk0");
    read_rk(4'd1, 128'h0, "z_rk1");
    read_rk(4'd2, 128'h62636363626363636263636362636363, "z_rk2");
    read_rk(4'd3, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb, "z_rk3");

    // 5. reset pulse after three expansion steps
    ks_if.key_v_i = 1'b1;
    ks_if.key_i   = KeyC3;
    tick();
    ks_if.key_v_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_keys_valid", ks_if.keys_valid_o, 0);
    check("abort_busy", ks_if.busy_o, 0);
    check("abort_ready", ks_if.key_ready_o, 1);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) read_rk(4'(i), 128'h0, $sformatf("abort_rk%0d", i));
    check("abort_keys_valid2", ks_if.keys_valid_o, 0);
    ks_if.key_v_i = 1'b1;
    ks_if.key_i   = KeyC3;
    tick();
    ks_if.key_v_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("again_keys_valid", ks_if.keys_valid_o, 1);
    read_rk(4'd2, 128'ha573c29fa176c498a97fce93a572c09c, "again_rk2");
    read_rk(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "again_rk14");

`ifdef AES_KS_ZEROIZE_EN
    // 6. zeroize in READY
    ks_if.zeroize_i = 1'b1;
    tick();
    ks_if.zeroize_i = 1'b0;
    check("zz_keys_valid", ks_if.keys_valid_o, 0);
    check("zz_ready", ks_if.key_ready_o, 1);
    for (int i = 0; i < 15; i++) read_rk(4'(i), 128'h0, $sformatf("zz_rk%0d", i));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
